// File: rtl/alu_pkg.sv
// Shared types for the pico-MIPS ALU arbiter.
// ALU_ARB_RR_EN selects round-robin arbitration in alu_arb_pick.
package alu_pkg;

  localparam int N_DEF = 8;
  localparam int F_DEF = 3;

  // Values match the processor's alucodes.
  typedef enum logic [2:0] {
    RA   = 3'b000,
    RB   = 3'b001,
    RADD = 3'b010,
    RSUB = 3'b011,
    RAND = 3'b100,
    ROR  = 3'b101,
    RXOR = 3'b110,
    RMUL = 3'b111
  } alu_func_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef logic port_t;

  localparam port_t P0 = 1'b0;
  localparam port_t P1 = 1'b1;

  function automatic port_t other(input port_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational grant between the two ALU requesters.
// ALU_ARB_RR_EN: round-robin on contention, else port 0 wins.
module alu_arb_pick
  import alu_pkg::*;
(
`ifdef ALU_ARB_RR_EN
  input  port_t rr,
`endif
  input  logic  valid0,
  input  logic  valid1,
  output port_t gnt,
  output logic  any
);

  always_comb begin
    any = valid0 | valid1;
    gnt = P0;
    unique case (1'b1)
      (valid0 && valid1): begin
`ifdef ALU_ARB_RR_EN
        gnt = rr;
`else
        gnt = P0;
`endif
      end
      (valid1 && !valid0): gnt = P1;
      default: gnt = P0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters, one op in flight.
// ALU_ARB_RR_EN enables the round-robin pointer.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int F = F_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [F-1:0] req0_func,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_result,
  output logic         rsp0_zf,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [F-1:0] req1_func,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_result,
  output logic         rsp1_zf,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [F-1:0] alu_func,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zf
);

  arb_state_t state;
  arb_state_t state_nxt;
  port_t      owner;
  port_t      gnt;
  logic       any;
  logic       accept;
  logic       rsp_take;

  logic [N-1:0] sel_a;
  logic [N-1:0] sel_b;
  logic [F-1:0] sel_func;

`ifdef ALU_ARB_RR_EN
  port_t rr;

  alu_arb_pick u_pick (
    .rr     (rr),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .gnt    (gnt),
    .any    (any)
  );

  // Pointer moves only on a grant, toward the loser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr <= P0;
    end else if (accept) begin
      rr <= other(gnt);
    end
  end
`else
  alu_arb_pick u_pick (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .gnt    (gnt),
    .any    (any)
  );
`endif

  assign sel_a    = (gnt == P1) ? req1_a    : req0_a;
  assign sel_b    = (gnt == P1) ? req1_b    : req0_b;
  assign sel_func = (gnt == P1) ? req1_func : req0_func;

  assign rsp_take = (owner == P1) ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) begin
          accept     = 1'b1;
          req0_ready = (gnt == P0);
          req1_ready = (gnt == P1);
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = (owner == P0);
        rsp1_valid = (owner == P1);
        if (rsp_take) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ALU operands hold the last op until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= P0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_func <= F'(RA);
    end else if (accept) begin
      owner    <= gnt;
      alu_a    <= sel_a;
      alu_b    <= sel_b;
      alu_func <= sel_func;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_result <= '0;
      rsp0_zf     <= 1'b0;
      rsp1_result <= '0;
      rsp1_zf     <= 1'b0;
    end else if (state == EXEC) begin
      if (owner == P1) begin
        rsp1_result <= alu_result;
        rsp1_zf     <= alu_zf;
      end else begin
        rsp0_result <= alu_result;
        rsp0_zf     <= alu_zf;
      end
    end
  end

endmodule
